// File: rtl/jof32_exe_pkg.sv
// jof32_exe_pkg: shared operand-B selects, skid states and default widths for the JOF32 execute stage
package jof32_exe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam logic [2:0] ALU_SEL_REG   = 3'd0;
  localparam logic [2:0] ALU_SEL_IMM   = 3'd1;
  localparam logic [2:0] ALU_SEL_SHAMT = 3'd2;
  localparam logic [2:0] ALU_SEL_ZERO  = 3'd3;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
endpackage

// File: rtl/alu_operand_stage_operand_fwd.sv
// operand_fwd: picks the freshest value of one source register, MEM over WB over register file
module operand_fwd #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [DATA_W-1:0] i_reg_val,
  input  logic [REG_AW-1:0] i_reg_addr,
  input  logic              i_mem_valid,
  input  logic [REG_AW-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_valid,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_val,
  output logic              o_hit
);
  logic w_nz, w_mem_hit, w_wb_hit;
  always_comb begin
    w_nz      = i_reg_addr != '0;
    w_mem_hit = w_nz && i_mem_valid && (i_mem_addr == i_reg_addr);
    w_wb_hit  = w_nz && i_wb_valid && (i_wb_addr == i_reg_addr);
    o_hit     = w_mem_hit || w_wb_hit;
    o_val     = w_mem_hit ? i_mem_data : w_wb_hit ? i_wb_data : i_reg_val;
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: forwards and selects ALU operands, then holds them in a two-entry skid buffer
module alu_operand_stage
  import jof32_exe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_a_addr,
  input  logic [REG_AW-1:0] rs_b_addr,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] imm,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [2:0]        alu_sel,
  input  logic              fwd_mem_valid,
  input  logic [REG_AW-1:0] fwd_mem_addr,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              fwd_wb_valid,
  input  logic [REG_AW-1:0] fwd_wb_addr,
  input  logic [DATA_W-1:0] fwd_wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        out_alu_sel,
  output logic [CNT_W-1:0]  fwd_count
);
  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};
  logic [DATA_W-1:0] w_a, w_b, w_b_sel;
  logic              w_hit_a, w_hit_b, w_accept, w_pop, w_ld_head, w_ld_skid, w_ld_from_skid;
  logic [CNT_W+1:0]  w_sum;
  skid_state_t       r_state, w_next;
  logic [DATA_W-1:0] r_head_a, r_head_b, r_skid_a, r_skid_b;
  logic [2:0]        r_head_sel, r_skid_sel;
  logic [CNT_W-1:0]  r_cnt;

  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .i_reg_val(in_a), .i_reg_addr(rs_a_addr),
    .i_mem_valid(fwd_mem_valid), .i_mem_addr(fwd_mem_addr), .i_mem_data(fwd_mem_data),
    .i_wb_valid(fwd_wb_valid), .i_wb_addr(fwd_wb_addr), .i_wb_data(fwd_wb_data),
    .o_val(w_a), .o_hit(w_hit_a)
  );
  operand_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .i_reg_val(in_b), .i_reg_addr(rs_b_addr),
    .i_mem_valid(fwd_mem_valid), .i_mem_addr(fwd_mem_addr), .i_mem_data(fwd_mem_data),
    .i_wb_valid(fwd_wb_valid), .i_wb_addr(fwd_wb_addr), .i_wb_data(fwd_wb_data),
    .o_val(w_b), .o_hit(w_hit_b)
  );

  // selects 4..7 fall through to the shift amount, matching the old mux
  always_comb begin
    w_b_sel = alu_sel == ALU_SEL_REG  ? w_b :
              alu_sel == ALU_SEL_IMM  ? imm :
              alu_sel == ALU_SEL_ZERO ? '0  : DATA_W'(shamt);
  end

  assign in_ready    = r_state != FULL;
  assign out_valid   = r_state != EMPTY;
  assign op_a        = r_head_a;
  assign op_b        = r_head_b;
  assign out_alu_sel = r_head_sel;
  assign fwd_count   = r_cnt;
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_pop       = out_valid && out_ready;

  always_comb begin
    w_next         = r_state;
    w_ld_head      = 1'b0;
    w_ld_skid      = 1'b0;
    w_ld_from_skid = 1'b0;
    if (flush) w_next = EMPTY;
    else begin
      case (r_state)
        EMPTY: begin
          w_ld_head = w_accept;
          w_next    = w_accept ? ONE : EMPTY;
        end
        ONE: begin
          w_ld_head = w_accept && w_pop;
          w_ld_skid = w_accept && !w_pop;
          w_next    = w_ld_skid ? FULL : (w_pop && !w_accept) ? EMPTY : ONE;
        end
        FULL: begin
          w_ld_from_skid = w_pop;
          w_next         = w_pop ? ONE : FULL;
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_a   <= '0;
      r_head_b   <= '0;
      r_head_sel <= '0;
      r_skid_a   <= '0;
      r_skid_b   <= '0;
      r_skid_sel <= '0;
    end else begin
      if (w_ld_head) begin
        r_head_a   <= w_a;
        r_head_b   <= w_b_sel;
        r_head_sel <= alu_sel;
      end else if (w_ld_from_skid) begin
        r_head_a   <= r_skid_a;
        r_head_b   <= r_skid_b;
        r_head_sel <= r_skid_sel;
      end
      if (w_ld_skid) begin
        r_skid_a   <= w_a;
        r_skid_b   <= w_b_sel;
        r_skid_sel <= alu_sel;
      end
    end
  end

  // operand B only counts when its register value is what actually got selected
  assign w_sum = {2'b00, r_cnt} + (CNT_W+2)'(w_accept && w_hit_a)
               + (CNT_W+2)'(w_accept && w_hit_b && alu_sel == ALU_SEL_REG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= w_sum > CNT_MAX ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised execute-stage operand block for the JOF32 processor. It resolves ALU operand A and operand B, applying EX/MEM and MEM/WB forwarding and the operand-B source select (register, immediate, shift amount, zero). The resolved operand pair is captured into a two-entry skid-buffered pipeline register with valid/ready handshakes on both sides. It sits between the ID/EX boundary and the ALU, and replaces the purely combinational operand-B multiplexer.

## Interface
- DATA_W, 32: operand/data width
- REG_AW, 5: register-address width
- SHAMT_W, 5: shift-amount field width, zero-extended to DATA_W
- CNT_W, 16: forwarding-event counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream operands valid
- in_ready  out  1  block can accept (reset 1)
- rs_a_addr, rs_b_addr  in  REG_AW  source register numbers
- in_a, in_b  in  DATA_W  register-file read data
- imm  in  DATA_W  sign-extended immediate
- shamt  in  SHAMT_W  shift amount
- alu_sel  in  3  operand-B source select
- fwd_mem_valid, fwd_wb_valid  in  1  forwarding source writes a register
- fwd_mem_addr, fwd_wb_addr  in  REG_AW  destination register
- fwd_mem_data, fwd_wb_data  in  DATA_W  forwarded value
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  head entry valid (reset 0)
- out_ready  in  1  ALU consumes head
- op_a, op_b  out  DATA_W  resolved operands (reset 0)
- out_alu_sel  out  3  alu_sel travelling with the entry (reset 0)
- fwd_count  out  CNT_W  saturating count of forwarded operands (reset 0)

## Operation
- Forwarding applies per operand, on register values only:
  - MEM hit when fwd_mem_valid, fwd_mem_addr == rs_x_addr, and rs_x_addr != 0.
  - WB hit is checked the same way.
  - MEM has priority over WB; no hit means the register-file value is used.
  - Register 0 is never forwarded.
- Operand B select, applied after forwarding:
  - 0: forwarded reg B
  - 1: imm
  - 2: shamt zero-extended
  - 3: all zeros
  - 4–7: same as 2, which is the legacy default
- Operand A is always forwarded reg A.
- Operands are resolved and frozen at acceptance (in_valid && in_ready). Hazards that arise after capture belong to the hazard unit.
- Skid buffer states:
  - EMPTY: out_valid 0, in_ready 1.
  - ONE: out_valid 1, in_ready 1.
  - FULL: out_valid 1, in_ready 0.
- Transitions, with accept = in_valid && in_ready and pop = out_valid && out_ready:
  - EMPTY: accept → ONE.
  - ONE: accept && !pop → FULL (new entry to skid); accept && pop → ONE (head reloaded); pop only → EMPTY.
  - FULL: pop → ONE (skid moves to head); no accept is possible.
- Ordering is strictly FIFO.
- in_ready is a registered function of state only, with no combinational path from out_ready.
- fwd_count increments by the number of operands forwarded in an accepted cycle (0, 1 or 2, register-sourced only). It saturates at 2^CNT_W−1, is not cleared by flush, and is cleared only by reset.

## Timing
- Latency: an entry accepted at edge N has out_valid=1 after edge N, provided the buffer was EMPTY, or was ONE with a pop at edge N.
- Throughput: one entry per cycle when out_ready is held high.
- flush has highest priority. At the next edge:
  - state becomes EMPTY, out_valid becomes 0 and in_ready becomes 1.
  - An input offered in the flush cycle is discarded and is not counted.
  - op_a/op_b keep their stale values.
- While rst_n is low, all outputs are at their reset values. No capture occurs on the first edge after deassertion unless in_valid is high.
- Reset mid-operation discards all entries immediately, asynchronously.
- out_valid, op_a, op_b and out_alu_sel stay stable while out_valid && !out_ready.

## Structure
- Package jof32_exe_pkg:
  - ALU_SEL_REG=0, ALU_SEL_IMM=1, ALU_SEL_SHAMT=2, ALU_SEL_ZERO=3
  - skid state enum {EMPTY, ONE, FULL}
  - the default DATA_W/REG_AW
- Sub-module operand_fwd (combinational): register value, address, and both forwarding ports in; forwarded value and hit flag out. It is instantiated twice, for operands A and B.
- Top level holds the select logic, skid registers, state FSM and counter.

## Test plan
- Reset, then in_a=5, in_b=7, alu_sel=0, no forwarding, out_ready=1 → one cycle later op_a=5, op_b=7, fwd_count=0.
- rs_b_addr=3, MEM hit on r3 with 0xAA and WB hit on r3 with 0xBB, alu_sel=0 → op_b=0xAA, fwd_count +1. Repeat with rs_b_addr=0 → op_b=in_b, count unchanged.
- alu_sel=2, then 6, with shamt=0x1F → op_b=0x0000001F both times. alu_sel=3 → op_b=0. alu_sel=1 with imm=0xFFFFFFF0 → op_b=0xFFFFFFF0.
- out_ready=0 while 3 entries are offered → two accepted, in_ready=0. Release out_ready → outputs appear in order, in_ready returns to 1 a cycle later.
- flush while FULL, with in_valid high → out_valid=0 next cycle, nothing from before or during the flush is emitted.
- CNT_W=2, 3 cycles each forwarding both operands → fwd_count saturates at 3.
